// File: rtl/btb_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// btb_update_ctrl_if
//   Bundles the decode-stage branch resolution bus and the BTB write port
//   used by btb_update_ctrl.
//
//   Resolution bus (driven by the pipeline, the master side):
//     enable         pipeline advance (not stalled)
//     is_branch      ID holds a resolved branch/jump this cycle
//     actual_taken   resolved direction
//     actual_target  resolved target address
//     pred_taken     IF/ID-pipelined predicted direction
//     pred_hit       IF/ID-pipelined BTB valid bit
//     pred_target    IF/ID-pipelined BTB predicted target
//     id_pc_idx      IF/ID-pipelined PC[3:0], the BTB index
//   Controller outputs (driven by the controller, the slave side):
//     mispredict     combinational flush request for IF/ID
//     btb_wen        BTB write enable
//     btb_idx        BTB write index
//     btb_target     BTB write data
//     pend           write buffer occupied
// ---------------------------------------------------------------------------
interface btb_update_ctrl_if;
    logic        enable;
    logic        is_branch;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic        pred_taken;
    logic        pred_hit;
    logic [15:0] pred_target;
    logic [3:0]  id_pc_idx;

    logic        mispredict;
    logic        btb_wen;
    logic [3:0]  btb_idx;
    logic [15:0] btb_target;
    logic        pend;

    modport master (
        output enable, is_branch, actual_taken, actual_target,
               pred_taken, pred_hit, pred_target, id_pc_idx,
        input  mispredict, btb_wen, btb_idx, btb_target, pend
    );

    modport slave (
        input  enable, is_branch, actual_taken, actual_target,
               pred_taken, pred_hit, pred_target, id_pc_idx,
        output mispredict, btb_wen, btb_idx, btb_target, pend
    );
endinterface

// File: rtl/btb_update_ctrl.sv
// ---------------------------------------------------------------------------
// btb_update_ctrl
//   Decode-stage branch resolution and BTB write-back controller (writer side
//   of the 16-entry BTB). Compares the prediction carried down IF/ID against
//   the resolved outcome, raises a same-cycle mispredict, and queues BTB
//   updates through a 1-deep pending buffer so the write lands one cycle
//   after resolution. Also keeps saturating branch/mispredict counters.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous active-high reset
//     bus        btb_update_ctrl_if.slave (resolution inputs, BTB write port)
//     br_count   resolved branches, saturating, CNT_W bits
//     mis_count  mispredicts, saturating, CNT_W bits
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | write buffer empty, btb_wen held low
//   PEND  | buffer holds an entry; it is written on the next enable=1 cycle
// ---------------------------------------------------------------------------
module btb_update_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    btb_update_ctrl_if.slave bus,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        res;
    logic        mis_c;
    logic        need_wr;
    logic        capture;

    logic [3:0]  buf_idx;
    logic [15:0] buf_target;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Resolution qualifiers. The pred_* terms are only evaluated inside the
    // res branch so unknown prediction data on non-branch cycles stays out of
    // mispredict, need_wr and everything derived from them.
    always_comb begin
        res     = bus.enable & bus.is_branch;
        mis_c   = 1'b0;
        need_wr = 1'b0;
        if (res) begin
            mis_c   = (bus.actual_taken != bus.pred_taken) |
                      (bus.actual_taken & bus.pred_taken &
                       (bus.pred_target != bus.actual_target));
            need_wr = bus.actual_taken &
                      (~bus.pred_hit | (bus.pred_target != bus.actual_target));
        end
    end

    // Next-state. need_wr already implies enable, so a stalled PEND simply
    // holds its entry. In PEND with enable=1 the buffered entry is written
    // this cycle, which frees the buffer for a new capture in the same cycle.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (need_wr) begin
                    capture   = 1'b1;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (bus.enable) begin
                    if (need_wr) begin
                        capture   = 1'b1;
                        state_nxt = PEND;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write buffer; contents persist while IDLE so btb_idx/btb_target show
    // the last captured entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_idx    <= 4'd0;
            buf_target <= 16'd0;
        end else if (capture) begin
            buf_idx    <= bus.id_pc_idx;
            buf_target <= bus.actual_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            if (res && (br_count != CNT_MAX)) begin
                br_count <= br_count + 1'b1;
            end
            if (mis_c && (mis_count != CNT_MAX)) begin
                mis_count <= mis_count + 1'b1;
            end
        end
    end

    assign bus.mispredict = mis_c;
    assign bus.pend       = (state == PEND);
    assign bus.btb_wen    = (state == PEND) & bus.enable;
    assign bus.btb_idx    = buf_idx;
    assign bus.btb_target = buf_target;

endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;

    logic clk;
    logic rst;

    btb_update_ctrl_if a_if ();
    btb_update_ctrl_if b_if ();

    logic [15:0] br_a;
    logic [15:0] mis_a;
    logic [3:0]  br_b;
    logic [3:0]  mis_b;

    int total;
    int bad;

    btb_update_ctrl #(.CNT_W(16)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (a_if.slave),
        .br_count  (br_a),
        .mis_count (mis_a)
    );

    btb_update_ctrl #(.CNT_W(4)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (b_if.slave),
        .br_count  (br_b),
        .mis_count (mis_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive the same vector into both instances, then let it settle.
    task automatic step(input logic en, input logic isb, input logic at,
                        input logic [15:0] atgt, input logic pt, input logic ph,
                        input logic [15:0] ptgt, input logic [3:0] idx);
        a_if.enable = en;  b_if.enable = en;
        a_if.is_branch = isb;  b_if.is_branch = isb;
        a_if.actual_taken = at;  b_if.actual_taken = at;
        a_if.actual_target = atgt;  b_if.actual_target = atgt;
        a_if.pred_taken = pt;  b_if.pred_taken = pt;
        a_if.pred_hit = ph;  b_if.pred_hit = ph;
        a_if.pred_target = ptgt;  b_if.pred_target = ptgt;
        a_if.id_pc_idx = idx;  b_if.id_pc_idx = idx;
        #1;
    endtask

    task automatic idle(input logic en);
        step(en, 1'b0, 1'b0, 16'h0000, 1'bx, 1'bx, 16'hxxxx, 4'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle(1'b1);
        #10;
        check("rst_pend",    32'(a_if.pend),       32'd0);
        check("rst_wen",     32'(a_if.btb_wen),    32'd0);
        check("rst_idx",     32'(a_if.btb_idx),    32'd0);
        check("rst_target",  32'(a_if.btb_target), 32'd0);
        check("rst_br",      32'(br_a),            32'd0);
        check("rst_mis",     32'(mis_a),           32'd0);
        check("rst_mispred", 32'(a_if.mispredict), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // T1: cold miss, taken, predicted not-taken
        step(1, 1, 1, 16'h0040, 0, 0, 16'h0000, 4'd3);
        check("t1_mispred", 32'(a_if.mispredict), 32'd1);
        check("t1_wen_same", 32'(a_if.btb_wen),   32'd0);
        tick();
        check("t1_pend", 32'(a_if.pend), 32'd1);
        check("t1_br",   32'(br_a),      32'd1);
        check("t1_mis",  32'(mis_a),     32'd1);
        idle(1'b1);
        check("t1_wen",    32'(a_if.btb_wen),    32'd1);
        check("t1_idx",    32'(a_if.btb_idx),    32'd3);
        check("t1_target", 32'(a_if.btb_target), 32'h0040);
        check("x_mispred", 32'(a_if.mispredict), 32'd0);
        tick();
        check("t1_pend_clr", 32'(a_if.pend),    32'd0);
        check("t1_wen_clr",  32'(a_if.btb_wen), 32'd0);
        check("t1_idx_hold", 32'(a_if.btb_idx), 32'd3);

        // T2: correct taken prediction, BTB hit
        step(1, 1, 1, 16'h0040, 1, 1, 16'h0040, 4'd3);
        check("t2_mispred", 32'(a_if.mispredict), 32'd0);
        tick();
        check("t2_pend", 32'(a_if.pend), 32'd0);
        check("t2_br",   32'(br_a),      32'd2);
        check("t2_mis",  32'(mis_a),     32'd1);

        // T3: wrong target, then stall three cycles
        step(1, 1, 1, 16'h1234, 1, 1, 16'h1111, 4'd5);
        check("t3_mispred", 32'(a_if.mispredict), 32'd1);
        tick();
        check("t3_pend", 32'(a_if.pend), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 16'h5555, 0, 0, 16'h0000, 4'd9);
            check("t3_stall_wen",  32'(a_if.btb_wen),    32'd0);
            check("t3_stall_pend", 32'(a_if.pend),       32'd1);
            check("t3_stall_mis",  32'(a_if.mispredict), 32'd0);
            tick();
        end
        idle(1'b1);
        check("t3_wen",    32'(a_if.btb_wen),    32'd1);
        check("t3_idx",    32'(a_if.btb_idx),    32'd5);
        check("t3_target", 32'(a_if.btb_target), 32'h1234);
        tick();
        check("t3_pend_clr", 32'(a_if.pend), 32'd0);
        check("t3_br",       32'(br_a),      32'd3);
        check("t3_mis",      32'(mis_a),     32'd2);

        // T4: back-to-back updates to the same index
        step(1, 1, 1, 16'h00A0, 0, 0, 16'h0000, 4'd2);
        check("t4_mis_a0", 32'(a_if.mispredict), 32'd1);
        tick();
        step(1, 1, 1, 16'h00B0, 0, 0, 16'h0000, 4'd2);
        check("t4_wen_a0",    32'(a_if.btb_wen),    32'd1);
        check("t4_idx_a0",    32'(a_if.btb_idx),    32'd2);
        check("t4_target_a0", 32'(a_if.btb_target), 32'h00A0);
        tick();
        check("t4_pend_b0", 32'(a_if.pend), 32'd1);
        idle(1'b1);
        check("t4_wen_b0",    32'(a_if.btb_wen),    32'd1);
        check("t4_target_b0", 32'(a_if.btb_target), 32'h00B0);
        tick();
        check("t4_pend_clr", 32'(a_if.pend),    32'd0);
        check("t4_wen_clr",  32'(a_if.btb_wen), 32'd0);
        check("t4_br",       32'(br_a),         32'd5);
        check("t4_mis",      32'(mis_a),        32'd4);
        check("t4_br_b",     32'(br_b),         32'd5);

        // T5: 20 mispredicting not-taken branches; 4-bit counters saturate
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 16'h0000, 1, 1, 16'h0300, 4'(i));
            tick();
        end
        check("t5_br_b",  32'(br_b),      32'hF);
        check("t5_mis_b", 32'(mis_b),     32'hF);
        check("t5_br_a",  32'(br_a),      32'd25);
        check("t5_mis_a", 32'(mis_a),     32'd24);
        check("t5_pend",  32'(a_if.pend), 32'd0);

        // T6: async reset while a write is pending
        step(1, 1, 1, 16'h0777, 0, 0, 16'h0000, 4'd9);
        tick();
        check("t6_pend_pre", 32'(a_if.pend), 32'd1);
        idle(1'b1);
        check("t6_wen_pre", 32'(a_if.btb_wen), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_pend",   32'(a_if.pend),       32'd0);
        check("t6_wen",    32'(a_if.btb_wen),    32'd0);
        check("t6_idx",    32'(a_if.btb_idx),    32'd0);
        check("t6_target", 32'(a_if.btb_target), 32'd0);
        check("t6_br",     32'(br_a),            32'd0);
        check("t6_mis",    32'(mis_a),           32'd0);
        check("t6_br_b",   32'(br_b),            32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        idle(1'b1);
        check("t6_wen_after",  32'(a_if.btb_wen), 32'd0);
        tick();
        check("t6_pend_after", 32'(a_if.pend),    32'd0);
        check("t6_br_after",   32'(br_a),         32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
